// File: rtl/wb_bus_if_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_bus_if_pkg : shared widths, levels and FSM encodings for wb_bus_if  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package wb_bus_if_pkg;

  localparam int REG_BUS_W = 32;
  localparam logic STOP = 1'b1;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] WB_IDLE           = 2'b00;
  localparam logic [1:0] WB_BUSY           = 2'b01;
  localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/wb_bus_if_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_bus_if_if : Wishbone B4 classic signal bundle (master side naming)  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface wb_bus_if_if;
  import wb_bus_if_pkg::*;

  logic [REG_BUS_W-1:0] wb_data_i;
  logic                 wb_ack_i;
  logic [REG_BUS_W-1:0] wb_addr_o;
  logic [REG_BUS_W-1:0] wb_data_o;
  logic                 wb_we_o;
  logic [3:0]           wb_sel_o;
  logic                 wb_stb_o;
  logic                 wb_cyc_o;

  modport master (
    input  wb_data_i, wb_ack_i,
    output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output wb_data_i, wb_ack_i,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_bus_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_bus_if : single-access Wishbone master for one OpenMIPS port        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int STALL_BIT   = 1,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall_i,
  input  logic                 flush_i,
  input  logic                 cpu_ce_i,
  input  logic [REG_BUS_W-1:0] cpu_addr_i,
  input  logic [REG_BUS_W-1:0] cpu_data_i,
  input  logic                 cpu_we_i,
  input  logic [3:0]           cpu_sel_i,
  output logic [REG_BUS_W-1:0] cpu_data_o,
  output logic                 stallreq_o,
  output logic                 bus_err_o,
  wb_bus_if_if.master          wb
);

  localparam logic             c_timeout_en   = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(ACK_TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [REG_BUS_W-1:0] r_addr;
  logic [REG_BUS_W-1:0] r_wdata;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic                 r_cyc;
  logic [REG_BUS_W-1:0] r_rd_buf;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_bus_err;

  logic w_busy;
  logic w_stalled;
  logic w_issue;
  logic w_ack_done;
  logic w_timeout;
  logic w_abort;
  logic w_end;
  logic w_unused_stall;

  // Only the stall bit of the stage this port feeds matters here.
  assign w_unused_stall = ^stall_i;

  assign w_busy     = (r_state == WB_BUSY);
  assign w_stalled  = (stall_i[STALL_BIT] == STOP);
  assign w_issue    = (r_state == WB_IDLE) & cpu_ce_i & ~flush_i;
  assign w_ack_done = w_busy & ~flush_i & wb.wb_ack_i;
  assign w_timeout  = c_timeout_en & (r_cnt == c_timeout_last);
  assign w_abort    = w_busy & ~flush_i & ~wb.wb_ack_i & w_timeout;
  assign w_end      = w_busy & (flush_i | wb.wb_ack_i | w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WB_IDLE: begin
        if (w_issue) w_next_state = WB_BUSY;
      end
      WB_BUSY: begin
        if (flush_i)              w_next_state = WB_IDLE;
        else if (wb.wb_ack_i)     w_next_state = w_stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
        else if (w_timeout)       w_next_state = WB_IDLE;
      end
      WB_WAIT_FOR_STALL: begin
        if (flush_i || !w_stalled) w_next_state = WB_IDLE;
      end
      default: w_next_state = WB_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    case (r_state)
      WB_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
      end
      WB_BUSY: begin
        if (flush_i) begin
          stallreq_o = 1'b0;
        end else if (wb.wb_ack_i) begin
          cpu_data_o = r_we ? ZERO_WORD : wb.wb_data_i;
        end else if (!w_timeout) begin
          stallreq_o = 1'b1;
        end
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = r_rd_buf;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

  // Bus-side registers: loaded on issue, cleared whenever the access ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= ZERO_WORD;
      r_wdata   <= ZERO_WORD;
      r_we      <= 1'b0;
      r_sel     <= 4'b0000;
      r_cyc     <= 1'b0;
      r_rd_buf  <= ZERO_WORD;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_issue) begin
        r_addr  <= cpu_addr_i;
        r_wdata <= cpu_data_i;
        r_we    <= cpu_we_i;
        r_sel   <= cpu_sel_i;
        r_cyc   <= 1'b1;
        r_cnt   <= '0;
      end else if (w_end) begin
        r_addr  <= ZERO_WORD;
        r_wdata <= ZERO_WORD;
        r_we    <= 1'b0;
        r_sel   <= 4'b0000;
        r_cyc   <= 1'b0;
      end else if (w_busy && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack_done && !r_we) begin
        r_rd_buf <= wb.wb_data_i;
      end
    end
  end

  assign wb.wb_addr_o = r_addr;
  assign wb.wb_data_o = r_wdata;
  assign wb.wb_we_o   = r_we;
  assign wb.wb_sel_o  = r_sel;
  assign wb.wb_stb_o  = r_cyc;
  assign wb.wb_cyc_o  = r_cyc;
  assign bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: doc/wb_bus_if.md
Name: wb_bus_if

Overview:
- Wishbone B4 classic single-access master bridging one OpenMIPS pipeline port (instruction fetch or data memory) to the bus.
- It is the requester side of the stall/flush controller:
  - produces the `stallreq_from_if` / `stallreq_from_mem` request;
  - consumes the 6-bit `stall` vector and `flush`.
- Two instances sit in the top: one for IF, one for MEM.

Parameters:
- STALL_BIT, 1, index into stall_i of the pipeline register this port feeds (1 = if_id for IF instance, 4 = mem_wb for MEM instance).
- ACK_TIMEOUT, 255, BUSY cycles without ack before abort; 0 disables timeout.
- CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- stall_i  input  6  stall vector from the stall controller.
- flush_i  input  1  exception flush from the stall controller.
- cpu_ce_i  input  1  pipeline access request.
- cpu_addr_i  input  32  byte address.
- cpu_data_i  input  32  write data.
- cpu_we_i  input  1  1 = write.
- cpu_sel_i  input  4  byte lanes.
- cpu_data_o  output  32  read data to pipeline.
- stallreq_o  output  1  stall request to the stall controller.
- bus_err_o  output  1  one-cycle pulse on timeout abort.
- wb_data_i  input  32  slave read data.
- wb_ack_i  input  1  slave acknowledge.
- wb_addr_o  output  32  bus address.
- wb_data_o  output  32  bus write data.
- wb_we_o  output  1  bus write enable.
- wb_sel_o  output  4  bus byte select.
- wb_stb_o  output  1  strobe.
- wb_cyc_o  output  1  cycle.

Behaviour:
- Reset:
  - state = IDLE.
  - All wb_* outputs = 0.
  - rd_buf = 0, cnt = 0, bus_err_o = 0.
  - stallreq_o = 0, cpu_data_o = 0.
- The FSM, all wb_* outputs, rd_buf, cnt and bus_err_o are registered.
- stallreq_o and cpu_data_o are combinational from state and inputs.
- IDLE:
  - If cpu_ce_i = 1 and flush_i = 0:
    - next cycle wb_cyc_o = wb_stb_o = 1;
    - latch cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i onto wb_*;
    - cnt = 0; go BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
- BUSY, checked in priority order:
  1. flush_i = 1: deassert cyc/stb, clear wb_* to 0, go IDLE, discard any ack data. stallreq_o = 0.
  2. wb_ack_i = 1:
     - deassert cyc/stb, clear wb_* to 0;
     - rd_buf = wb_data_i on reads, unchanged on writes;
     - go WAIT_FOR_STALL if stall_i[STALL_BIT] = 1, else IDLE;
     - stallreq_o = 0;
     - cpu_data_o = wb_data_i on reads, 0 on writes.
  3. ACK_TIMEOUT != 0 and cnt == ACK_TIMEOUT-1:
     - abort as in flush;
     - bus_err_o = 1 for the next cycle only;
     - go IDLE; stallreq_o = 0 in the abort cycle.
  4. Otherwise: cnt = cnt+1 (saturating), stallreq_o = 1, cpu_data_o = 0.
- WAIT_FOR_STALL:
  - The pipeline is stalled by another stage, so the completed result is held.
  - stallreq_o = 0; cpu_data_o = rd_buf.
  - Go IDLE when stall_i[STALL_BIT] = 0, or immediately on flush_i.
  - Nothing is issued from this state.
- Minimum latency: request cycle plus ack cycle, i.e. 2 cycles per access with a zero-wait slave.
- One outstanding access only; a new access is never issued in the same cycle as an ack.
- Asynchronous reset in mid-transaction drops cyc/stb immediately with no completion.
- flush_i and cpu_ce_i together in IDLE: no issue.

Decomposition:
- Shared package/defines:
  - state encodings WB_IDLE = 2'b00, WB_BUSY = 2'b01, WB_WAIT_FOR_STALL = 2'b11;
  - existing RegBus width, Stop level, zero word.
- No sub-module; single FSM with a counter.

Test Plan:
- Read, zero-wait slave, addr 0x0000_0100, ack on first BUSY cycle with 0xDEAD_BEEF:
  - stallreq_o high 1 cycle (IDLE) and low on the ack cycle;
  - cpu_data_o = 0xDEAD_BEEF on the ack cycle;
  - cyc/stb high exactly 1 cycle.
- Write, 3-wait slave, addr 0x40, data 0x1234_5678, sel 4'b0011:
  - wb_* stable for 4 cycles; stallreq_o high for 4 cycles;
  - cpu_data_o = 0; back to IDLE after ack.
- Read ack 0xA5A5_0001 while stall_i[STALL_BIT] = 1 for 3 further cycles:
  - WAIT_FOR_STALL entered;
  - cpu_data_o = 0xA5A5_0001 throughout; stallreq_o = 0;
  - IDLE once the stall bit falls.
- flush_i asserted in the 2nd BUSY cycle, and separately on the same cycle as ack:
  - cyc/stb low next cycle; stallreq_o = 0;
  - rd_buf unchanged; state IDLE.
- ACK_TIMEOUT = 4, slave never acks:
  - cyc/stb high exactly 4 cycles, then low;
  - bus_err_o pulses 1 cycle; stallreq_o low from the abort cycle.
- rst asserted mid-BUSY:
  - all wb_* outputs and bus_err_o are 0 asynchronously;
  - first access after release proceeds normally.
